mtm_alu_sin_deserializer: RTL and testbench
===========================================

Name: mtm_alu_sin_deserializer

Overview:
Upstream stage of the MTM ALU checking path. It samples the serial `sin` line one bit per clock and reassembles the 11-bit frames into a complete ALU request: B, A, op and CRC. It validates frame count, CRC and op code, then presents one decoded request per packet on a valid/ready interface. The ALU model and the comparison logic consume this interface.

Parameters:
DATA_FRAMES, 8, number of data frames expected before the CTL frame (B3..B0, then A3..A0)
TIMEOUT_CYCLES, 1023, idle cycles between frames before a partial packet is aborted (only with the optional feature)

Ports:
clk  input  1  single clock; `sin` is sampled on the rising edge
reset  input  1  synchronous, active-high reset
sin  input  1  serial ALU input line; idles at 1
out_valid  output  1  decoded request available
out_ready  input  1  consumer accepts the request
out_A  output  32  operand A
out_B  output  32  operand B
out_op  output  3  op field from the CTL frame
out_crc  output  4  CRC received in the CTL frame
out_err  output  1  packet has at least one error
out_err_flags  output  3  {ERR_DATA, ERR_CRC, ERR_OP}
overflow  output  1  one-cycle pulse: a completed packet was dropped
busy  output  1  a packet is partially received

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, overflow=0, busy=0, and out_A, out_B, out_op, out_crc, out_err, out_err_flags all 0. Reset also clears the frame counter, CRC and FSM. A reset mid-packet discards the packet.
- Frame format, in sample order: start bit (0), type bit (0 = DATA, 1 = CTL), 8 payload bits MSB first, stop bit (1).
- FSM states:
  - IDLE: sin==0 counts as the start bit; go to SHIFT with bitcnt=1.
  - SHIFT: capture 10 more bits; after bitcnt reaches 10, go to EVAL.
  - EVAL (1 cycle): act on the frame, then return to IDLE. A frame can start on the cycle after EVAL.
- DATA frame:
  - While datacnt<DATA_FRAMES, shift the payload into {B,A} MSB first; datacnt increments.
  - At datacnt==DATA_FRAMES the payload is discarded, datacnt saturates and ERR_DATA is latched.
- CTL frame payload = {1'b0, op[2:0], crc[3:0]}. Flag evaluation:
  - ERR_DATA if datacnt!=DATA_FRAMES, or if ERR_DATA is already latched.
  - Otherwise ERR_CRC if crc != CRC4({B, A, 1'b1, op}).
  - Otherwise ERR_OP if op is not one of 000 AND, 001 OR, 100 ADD, 101 SUB.
  - Exactly one flag is set per errored packet, in that priority order.
  - out_err = |flags.
  - The packet then completes and datacnt, {B,A} and the latched error are cleared.
- CRC4: polynomial x^4+x+1, init 0, MSB first; per bit fb=c[3]^d, c={c[2:0],0}^(fb?4'b0011:0). Computed serially or combinationally in EVAL; either is acceptable.
- Bad stop bit (0) on any frame: latch ERR_DATA. The frame is otherwise processed normally.
- Output latency: out_valid rises on the cycle after EVAL of the CTL frame. Outputs are stable while out_valid && !out_ready. Transfer happens on out_valid && out_ready.
- Completion while out_valid=1 and out_ready=0: the new packet is dropped, the held output is unchanged, and overflow pulses for 1 cycle.
- Completion in the same cycle as a transfer: the new packet is loaded and out_valid stays 1.
- busy=1 from the first start bit of a packet until its CTL EVAL.

Optional Feature:
- Macro: MTM_DESER_TIMEOUT_EN.
- When defined: an idle counter runs in IDLE while busy=1. When it reaches TIMEOUT_CYCLES, the partial packet is aborted: datacnt, {B,A} and latched errors are cleared and busy drops. No output is produced.
- When undefined: no counter exists and a partial packet waits indefinitely.

Test Plan:
- 8 DATA frames of 0x00, then CTL 0x0B (op AND, crc 1011) -> out_valid 1 clk after CTL EVAL; A=0, B=0, op=000, err=0.
- Same packet with CTL 0x0A -> err=1, flags=010 (ERR_CRC).
- 7 DATA frames, then CTL 0x0B -> flags=100 (ERR_DATA). A following valid packet decodes with err=0.
- 8 DATA frames of 0x00, then CTL with op=010 and a correct CRC -> flags=001 (ERR_OP).
- Two valid packets with out_ready held 0 -> first packet held, overflow pulses once, and the first packet is delivered when out_ready=1.
- Reset asserted after 3 DATA frames, then a full valid packet -> only the full packet is output, err=0. With MTM_DESER_TIMEOUT_EN: 3 frames followed by TIMEOUT_CYCLES of idle -> busy=0 and no output.

Source files
------------

// File: rtl/mtm_alu_sin_deserializer.sv
// -----------------------------------------------------------------------------
// mtm_alu_sin_deserializer
//
// Samples the serial ALU input line one bit per clock and rebuilds 11-bit
// frames: start(0), type(0=DATA,1=CTL), 8 payload bits MSB first, stop(1).
// Eight DATA frames (B3..B0, A3..A0) followed by one CTL frame
// {1'b0, op[2:0], crc[3:0]} form one request. The request is validated
// (frame count / stop bits, CRC4 over {B, A, 1'b1, op}, op code), then
// presented on a valid/ready output.
//
// Optional feature, macro MTM_DESER_TIMEOUT_EN: when defined, a partial
// packet is aborted after TIMEOUT_CYCLES idle cycles between frames.
//
// Ports:
//   clk            clock, sin sampled on the rising edge
//   reset          synchronous, active-high
//   sin            serial input, idles at 1
//   out_valid      decoded request available
//   out_ready      consumer accepts the request
//   out_A, out_B   operands (32 bit each)
//   out_op         op field of the CTL frame
//   out_crc        CRC received in the CTL frame
//   out_err        packet has an error (OR of the flags)
//   out_err_flags  {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set
//   overflow       one-cycle pulse: a completed packet was dropped
//   busy           a packet is partially received
//
// Handshake: a request transfers on a cycle where out_valid && out_ready.
// While out_valid && !out_ready every out_* field is held stable. A packet
// completing while the output is held is dropped (overflow pulses); one
// completing on a transfer cycle is loaded and out_valid stays high.
// -----------------------------------------------------------------------------
module mtm_alu_sin_deserializer #(
  parameter int DATA_FRAMES    = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [2:0]  out_op,
  output logic [3:0]  out_crc,
  output logic        out_err,
  output logic [2:0]  out_err_flags,
  output logic        overflow,
  output logic        busy
);

  localparam int CNT_W = $clog2(DATA_FRAMES + 1);
  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(DATA_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_bitcnt;
  logic [9:0]       r_shift;      // {type, payload[7:0], stop}
  logic [CNT_W-1:0] r_datacnt;
  logic [63:0]      r_ba;         // {B, A}
  logic             r_err_data;
  logic             r_busy;
  logic             r_out_valid;
  logic             r_overflow;
  logic [31:0]      r_out_a;
  logic [31:0]      r_out_b;
  logic [2:0]       r_out_op;
  logic [3:0]       r_out_crc;
  logic             r_out_err;
  logic [2:0]       r_out_flags;

`ifdef MTM_DESER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_idle_cnt;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

  // CRC4, poly x^4+x+1, init 0, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  logic       w_type;
  logic       w_stop_ok;
  logic [7:0] w_payload;
  logic [2:0] w_op;
  logic [3:0] w_crc_rx;
  logic [3:0] w_crc_calc;
  logic       w_data_full;
  logic       w_op_ok;
  logic       w_err_data;
  logic       w_err_crc;
  logic       w_err_op;
  logic       w_load;

  assign w_type      = r_shift[9];
  assign w_payload   = r_shift[8:1];
  assign w_stop_ok   = r_shift[0];
  assign w_op        = w_payload[6:4];
  assign w_crc_rx    = w_payload[3:0];
  assign w_crc_calc  = crc4({r_ba, 1'b1, w_op});
  assign w_data_full = (r_datacnt == DATA_FULL);
  assign w_op_ok     = (w_op == 3'b000) || (w_op == 3'b001) ||
                       (w_op == 3'b100) || (w_op == 3'b101);

  // Flag priority for a CTL frame: data > crc > op. A bad stop bit on the
  // CTL frame itself counts as a data error.
  assign w_err_data  = r_err_data | ~w_stop_ok | ~w_data_full;
  assign w_err_crc   = ~w_err_data & (w_crc_rx != w_crc_calc);
  assign w_err_op    = ~w_err_data & ~w_err_crc & ~w_op_ok;

  // Output register may take a new packet when empty or being drained.
  assign w_load      = ~r_out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 10'd0;
      r_datacnt   <= '0;
      r_ba        <= 64'd0;
      r_err_data  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_a     <= 32'd0;
      r_out_b     <= 32'd0;
      r_out_op    <= 3'd0;
      r_out_crc   <= 4'd0;
      r_out_err   <= 1'b0;
      r_out_flags <= 3'd0;
`ifdef MTM_DESER_TIMEOUT_EN
      r_idle_cnt  <= '0;
`endif
    end else begin
      r_overflow <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!sin) begin
            r_state  <= S_SHIFT;
            r_bitcnt <= 4'd1;
            r_busy   <= 1'b1;
          end
        end

        S_SHIFT: begin
          r_shift  <= {r_shift[8:0], sin};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == 4'd10) begin
            r_state <= S_EVAL;
          end
        end

        S_EVAL: begin
          r_state <= S_IDLE;
          if (!w_type) begin
            if (!w_data_full) begin
              r_ba      <= {r_ba[55:0], w_payload};
              r_datacnt <= r_datacnt + 1'b1;
            end else begin
              r_err_data <= 1'b1;
            end
            if (!w_stop_ok) begin
              r_err_data <= 1'b1;
            end
          end else begin
            r_datacnt  <= '0;
            r_ba       <= 64'd0;
            r_err_data <= 1'b0;
            r_busy     <= 1'b0;
            if (w_load) begin
              r_out_valid <= 1'b1;
              r_out_b     <= r_ba[63:32];
              r_out_a     <= r_ba[31:0];
              r_out_op    <= w_op;
              r_out_crc   <= w_crc_rx;
              r_out_err   <= w_err_data | w_err_crc | w_err_op;
              r_out_flags <= {w_err_data, w_err_crc, w_err_op};
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase

`ifdef MTM_DESER_TIMEOUT_EN
      // Only idle-line cycles between frames of a partial packet count;
      // a start bit restarts the count.
      if ((r_state == S_IDLE) && r_busy && sin) begin
        if (r_idle_cnt == TO_LIMIT) begin
          r_idle_cnt <= '0;
          r_datacnt  <= '0;
          r_ba       <= 64'd0;
          r_err_data <= 1'b0;
          r_busy     <= 1'b0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end else begin
        r_idle_cnt <= '0;
      end
`endif
    end
  end

  assign out_valid     = r_out_valid;
  assign out_A         = r_out_a;
  assign out_B         = r_out_b;
  assign out_op        = r_out_op;
  assign out_crc       = r_out_crc;
  assign out_err       = r_out_err;
  assign out_err_flags = r_out_flags;
  assign overflow      = r_overflow;
  assign busy          = r_busy;

endmodule

// File: tb/tb_mtm_alu_sin_deserializer.sv
// -----------------------------------------------------------------------------
// tb_mtm_alu_sin_deserializer
//
// Directed and randomized packets are serialized onto sin. Expected requests
// come from a packet-level model (byte list -> operands, CRC by polynomial
// division, flag priority) and are pushed into exp_q; a monitor pops and
// compares on every transfer.
// -----------------------------------------------------------------------------
module tb_mtm_alu_sin_deserializer;

  localparam int TIMEOUT_CYCLES = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        sin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [2:0]  out_op;
  logic [3:0]  out_crc;
  logic        out_err;
  logic [2:0]  out_err_flags;
  logic        overflow;
  logic        busy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mtm_alu_sin_deserializer dut (
    .clk           (clk),
    .reset         (reset),
    .sin           (sin),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_A         (out_A),
    .out_B         (out_B),
    .out_op        (out_op),
    .out_crc       (out_crc),
    .out_err       (out_err),
    .out_err_flags (out_err_flags),
    .overflow      (overflow),
    .busy          (busy)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int ovf_cnt = 0;

  // Request record: {A, B, op, crc, err, flags}
  logic [74:0] exp_q[$];
  // Frame record: {stop_ok, is_ctl, payload[7:0]}
  logic [9:0]  pkt_q[$];

  logic [74:0] w_obs;
  assign w_obs = {out_A, out_B, out_op, out_crc, out_err, out_err_flags};

  // ---------------- reference model ----------------
  // CRC as remainder of msg(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [74:0] model_out();
    logic [63:0] ba;
    int          nd;
    bit          bad;
    logic [9:0]  last;
    logic [2:0]  op;
    logic [3:0]  crc;
    logic [2:0]  flags;
    ba  = 64'd0;
    nd  = 0;
    bad = 0;
    for (int i = 0; i < pkt_q.size() - 1; i++) begin
      if (!pkt_q[i][9]) bad = 1;
      if (nd < 8) ba = (ba << 8) | 64'(pkt_q[i][7:0]);
      nd++;
    end
    last = pkt_q[pkt_q.size() - 1];
    if (!last[9]) bad = 1;
    op  = last[6:4];
    crc = last[3:0];
    if (bad || nd != 8)                       flags = 3'b100;
    else if (crc != crc_ref({ba, 1'b1, op}))  flags = 3'b010;
    else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) flags = 3'b001;
    else                                      flags = 3'b000;
    return {ba[31:0], ba[63:32], op, crc, |flags, flags};
  endfunction

  // ---------------- check / scoreboard ----------------
  task automatic check(input string tag, input logic [74:0] got, input logic [74:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL spurious_out: observed %h expected no request", w_obs);
      end
      if (exp_q.size() != 0) check("request", w_obs, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [9:0] f);
    send_bit(1'b0);
    send_bit(f[8]);
    for (int i = 7; i >= 0; i--) send_bit(f[i]);
    send_bit(f[9]);
  endtask

  task automatic add_data(input logic [7:0] b);
    pkt_q.push_back({1'b1, 1'b0, b});
  endtask

  task automatic add_ctl(input logic [7:0] p);
    pkt_q.push_back({1'b1, 1'b1, p});
  endtask

  // Sends pkt_q; returns with the CTL frame in its evaluation cycle.
  task automatic run_packet(input bit push);
    if (push) exp_q.push_back(model_out());
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_frame(pkt_q[i]);
      if (i != pkt_q.size() - 1) idle($urandom_range(1, 3));
    end
    pkt_q.delete();
  endtask

  task automatic make_valid();
    logic [63:0] ba;
    logic [2:0]  op;
    ba = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: op = 3'b000;
      1: op = 3'b001;
      2: op = 3'b100;
      default: op = 3'b101;
    endcase
    for (int i = 0; i < 8; i++) add_data(ba[63 - 8*i -: 8]);
    add_ctl({1'b0, op, crc_ref({ba, 1'b1, op})});
  endtask

  task automatic make_random();
    logic [63:0] ba;
    logic [2:0]  op;
    logic [3:0]  crc;
    int          nd;
    ba = {$urandom, $urandom};
    op = 3'($urandom_range(0, 7));
    nd = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 9) : 8;
    for (int i = 0; i < nd; i++) add_data((i < 8) ? ba[63 - 8*i -: 8] : 8'($urandom));
    crc = ($urandom_range(0, 9) < 7) ? crc_ref({ba, 1'b1, op}) : 4'($urandom_range(0, 15));
    add_ctl({1'b0, op, crc});
    if ($urandom_range(0, 19) == 0) pkt_q[$urandom_range(0, pkt_q.size() - 1)][9] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) send_bit(1'b1);
    check(tag, 75'(exp_q.size()), 75'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    sin       = 1'b1;
    out_ready = 1'b1;
    idle(3);
    check("reset_state", {out_valid, overflow, busy, w_obs}, '0);
    reset = 1'b0;
    idle(2);

    // All-zero operands, AND, correct CRC 1011; latency check.
    for (int i = 0; i < 8; i++) add_data(8'h00);
    add_ctl(8'h0B);
    run_packet(1);
    check("t1_in_eval", {out_valid, busy}, 2'b01);
    send_bit(1'b1);
    check("t1_valid_next", {out_valid, busy}, 2'b10);
    check("t1_fields", w_obs, 75'h0B0);
    wait_drain("t1_drain");

    // Wrong CRC.
    for (int i = 0; i < 8; i++) add_data(8'h00);
    add_ctl(8'h0A);
    run_packet(1);
    send_bit(1'b1);
    check("t2_crc_err", w_obs, 75'h0AA);
    wait_drain("t2_drain");

    // Seven data frames, then a valid packet decodes cleanly.
    for (int i = 0; i < 7; i++) add_data(8'h00);
    add_ctl(8'h0B);
    run_packet(1);
    send_bit(1'b1);
    check("t3_data_err", w_obs, 75'h0BC);
    wait_drain("t3_drain");
    make_valid();
    run_packet(1);
    send_bit(1'b1);
    check("t3_next_ok", {out_valid, out_err}, 2'b10);
    wait_drain("t3b_drain");

    // Illegal op 010 with matching CRC 1101.
    for (int i = 0; i < 8; i++) add_data(8'h00);
    add_ctl(8'h2D);
    run_packet(1);
    send_bit(1'b1);
    check("t4_op_err", w_obs, 75'h2D9);
    wait_drain("t4_drain");

    // Back-pressure: second packet dropped, overflow one cycle.
    check("t5_no_ovf_yet", 75'(ovf_cnt), 75'd0);
    out_ready = 1'b0;
    make_valid();
    run_packet(1);
    send_bit(1'b1);
    make_valid();
    run_packet(0);
    idle(3);
    check("t5_ovf_once", 75'(ovf_cnt), 75'd1);
    check("t5_held_valid", 75'(out_valid), 75'd1);
    if (exp_q.size() != 0) check("t5_held_data", w_obs, exp_q[0]);
    out_ready = 1'b1;
    wait_drain("t5_drain");
    idle(2);
    check("t5_released", 75'(out_valid), 75'd0);

    // Reset mid-packet discards the partial packet.
    for (int i = 0; i < 3; i++) begin
      send_frame({1'b1, 1'b0, 8'($urandom)});
      idle(1);
    end
    check("t6_busy_partial", 75'(busy), 75'd1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("t6_after_reset", {out_valid, busy}, 2'b00);
    make_valid();
    run_packet(1);
    send_bit(1'b1);
    check("t6_full_ok", {out_valid, out_err}, 2'b10);
    wait_drain("t6_drain");

    // Bad stop bit on a data frame.
    make_valid();
    pkt_q[3][9] = 1'b0;
    run_packet(1);
    send_bit(1'b1);
    check("t7_stop_flags", 75'(out_err_flags), 75'b100);
    wait_drain("t7_drain");

    // Nine data frames.
    make_valid();
    pkt_q.insert(4, {1'b1, 1'b0, 8'hA5});
    run_packet(1);
    send_bit(1'b1);
    check("t8_extra_flags", 75'(out_err_flags), 75'b100);
    wait_drain("t8_drain");

`ifdef MTM_DESER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      send_frame({1'b1, 1'b0, 8'($urandom)});
      idle(1);
    end
    idle(TIMEOUT_CYCLES - 10);
    check("t9_busy_before_to", 75'(busy), 75'd1);
    idle(20);
    check("t9_aborted", {out_valid, busy}, 2'b00);
    make_valid();
    run_packet(1);
    send_bit(1'b1);
    check("t9_next_ok", {out_valid, out_err}, 2'b10);
    wait_drain("t9_drain");
`endif

    // Randomized packets with random hold time.
    for (int p = 0; p < 25; p++) begin
      out_ready = 1'b0;
      make_random();
      run_packet(1);
      send_bit(1'b1);
      idle($urandom_range(0, 4));
      check("rand_held_valid", 75'(out_valid), 75'd1);
      if (exp_q.size() != 0) check("rand_held_data", w_obs, exp_q[0]);
      out_ready = 1'b1;
      wait_drain("rand_drain");
      idle($urandom_range(1, 4));
    end

    check("final_ovf_total", 75'(ovf_cnt), 75'd1);
    check("final_queue_empty", 75'(exp_q.size()), 75'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
